// File: rtl/sram_port_arb.sv
// Shares one single-port 32-bit SRAM between the instruction-fetch (I) and load/store (D) ports.
// D has fixed priority. A starvation guard hands priority to I after MAX_WAIT denied cycles.
module sram_port_arb #(
    parameter int AW       = 14,
    parameter int MAX_WAIT = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [15:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [15:0]   d_addr,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_wd,
    input  logic [3:0]    d_re,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_e,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wd,
    output logic [3:0]    mem_re,
    input  logic [31:0]   mem_rd,
    output logic [CW-1:0] i_stall_cnt,
    output logic [CW-1:0] d_stall_cnt
);

    localparam logic [0:0] NORM   = 1'b0;
    localparam logic [0:0] STARVE = 1'b1;

    typedef struct packed {
        logic       i_rd;
        logic       d_rd;
        logic [3:0] re_mask;
    } tag_t;

    logic [0:0]    state, state_d;
    logic [3:0]    wait_cnt;
    logic [4:0]    wait_inc;
    logic [AW-1:0] a_q;
    logic [31:0]   wd_q;
    tag_t          tag;
    logic          d_wr, d_rd_op, i_stalled, d_stalled;

    assign d_wr      = |d_we;
    assign d_rd_op   = !d_wr && (|d_re);
    assign i_gnt     = i_req && ((state == STARVE) || !d_req);
    assign d_gnt     = d_req && !((state == STARVE) && i_req);
    assign i_stalled = i_req && !i_gnt;
    assign d_stalled = d_req && !d_gnt;
    assign wait_inc  = {1'b0, wait_cnt} + 5'd1;

    // A D grant with no enables is accepted but never reaches the SRAM.
    assign mem_e  = i_gnt || (d_gnt && (d_wr || d_rd_op));
    assign mem_we = (d_gnt && d_wr) ? d_we : 4'h0;
    assign mem_re = i_gnt ? 4'hF : ((d_gnt && d_rd_op) ? d_re : 4'h0);
    assign mem_a  = i_gnt ? i_addr[AW+1:2] : (d_gnt ? d_addr[AW+1:2] : a_q);
    assign mem_wd = d_gnt ? d_wd : wd_q;

    always_comb begin
        state_d = state;
        case (state)
            NORM:    if (i_stalled && (wait_inc >= 5'(MAX_WAIT))) state_d = STARVE;
            default: if (i_gnt) state_d = NORM;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state       <= NORM;
            wait_cnt    <= 4'h0;
            a_q         <= '0;
            wd_q        <= '0;
            tag         <= '0;
            i_stall_cnt <= '0;
            d_stall_cnt <= '0;
        end else begin
            state    <= state_d;
            a_q      <= mem_a;
            wd_q     <= mem_wd;
            tag.i_rd    <= i_gnt;
            tag.d_rd    <= d_gnt && d_rd_op;
            tag.re_mask <= mem_re;
            if (i_stalled) wait_cnt <= (wait_cnt == 4'hF) ? wait_cnt : wait_inc[3:0];
            else           wait_cnt <= 4'h0;
            if (i_stalled && (i_stall_cnt != '1)) i_stall_cnt <= i_stall_cnt + CW'(1);
            if (d_stalled && (d_stall_cnt != '1)) d_stall_cnt <= d_stall_cnt + CW'(1);
        end
    end

    assign i_rvalid = tag.i_rd;
    assign d_rvalid = tag.d_rd;
    assign i_rdata  = tag.i_rd ? mem_rd : 32'h0;

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign d_rdata[8*b +: 8] = (tag.d_rd && tag.re_mask[b]) ? mem_rd[8*b +: 8] : 8'h0;
    end

    // Byte-offset bits never select a word.
    logic unused_lo;
    assign unused_lo = &{1'b0, i_addr[1:0], d_addr[1:0]};
    if (AW < 14) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = &{1'b0, i_addr[15:AW+2], d_addr[15:AW+2]};
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Scoreboarded bench for sram_port_arb: read grants queue expected returns, a negedge monitor checks them.
module tb_sram_port_arb;

    logic        clk, rstn;
    logic        i_req, d_req;
    logic [15:0] i_addr, d_addr;
    logic [3:0]  d_we, d_re;
    logic [31:0] d_wd, mem_rd;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_e;
    logic [31:0] i_rdata, d_rdata, mem_wd;
    logic [13:0] mem_a;
    logic [3:0]  mem_we, mem_re;
    logic [15:0] i_stall_cnt, d_stall_cnt;
    logic        s_i_gnt, s_i_rvalid, s_d_gnt, s_d_rvalid, s_mem_e;
    logic [31:0] s_i_rdata, s_d_rdata, s_mem_wd;
    logic [13:0] s_mem_a;
    logic [3:0]  s_mem_we, s_mem_re;
    logic [3:0]  s_i_stall_cnt, s_d_stall_cnt;

    sram_port_arb dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_e(mem_e), .mem_we(mem_we), .mem_wd(mem_wd), .mem_re(mem_re),
        .mem_rd(mem_rd), .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    sram_port_arb #(.CW(4)) dut_sat (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .mem_a(s_mem_a), .mem_e(s_mem_e), .mem_we(s_mem_we), .mem_wd(s_mem_wd), .mem_re(s_mem_re),
        .mem_rd(mem_rd), .i_stall_cnt(s_i_stall_cnt), .d_stall_cnt(s_d_stall_cnt)
    );

    typedef struct {
        int          due;
        logic [31:0] mask;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   cyc = 0;
    int   vec = 0;
    int   fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rmask(input logic [3:0] re);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{re[b]}};
        return m;
    endfunction

    // Every cycle: a due scoreboard entry must come back, otherwise rvalid/rdata must be quiet.
    always @(negedge clk) begin
        vec++;
        if (iq.size() > 0 && iq[0].due == cyc) begin
            if (i_rvalid !== 1'b1 || i_rdata !== (mem_rd & iq[0].mask)) begin
                fail++;
                $display("FAIL i_return cyc %0d: got v=%b d=%h want v=1 d=%h", cyc, i_rvalid, i_rdata, mem_rd & iq[0].mask);
            end
            void'(iq.pop_front());
        end else if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            fail++;
            $display("FAIL i_idle cyc %0d: got v=%b d=%h want v=0 d=0", cyc, i_rvalid, i_rdata);
        end
        vec++;
        if (dq.size() > 0 && dq[0].due == cyc) begin
            if (d_rvalid !== 1'b1 || d_rdata !== (mem_rd & dq[0].mask)) begin
                fail++;
                $display("FAIL d_return cyc %0d: got v=%b d=%h want v=1 d=%h", cyc, d_rvalid, d_rdata, mem_rd & dq[0].mask);
            end
            void'(dq.pop_front());
        end else if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
            fail++;
            $display("FAIL d_idle cyc %0d: got v=%b d=%h want v=0 d=0", cyc, d_rvalid, d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rd = $urandom;
    endtask

    task automatic push_i();
        iq.push_back('{due: cyc + 1, mask: 32'hFFFF_FFFF});
    endtask

    task automatic push_d(input logic [3:0] re);
        dq.push_back('{due: cyc + 1, mask: rmask(re)});
    endtask

    task automatic clear_inputs();
        i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_we = 0; d_wd = 0; d_re = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        tick();
        rstn = 1;
        iq.delete();
        dq.delete();
        tick();
        rstn = 0;
    endtask

    task automatic test_reset();
        rstn = 1;
        clear_inputs();
        mem_rd = 32'hDEAD_BEEF;
        tick();
        #1;
        vec++; if (i_rvalid !== 0 || d_rvalid !== 0) begin fail++; $display("FAIL reset_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
        vec++; if (i_stall_cnt !== 0 || d_stall_cnt !== 0) begin fail++; $display("FAIL reset_cnt: got %h %h want 0 0", i_stall_cnt, d_stall_cnt); end
        vec++; if (mem_e !== 0 || mem_a !== 0 || mem_re !== 0 || mem_we !== 0) begin fail++; $display("FAIL reset_mem: got e=%b a=%h re=%h we=%h want 0", mem_e, mem_a, mem_re, mem_we); end
        i_req = 1; i_addr = 16'h0020;
        #1;
        vec++; if (i_gnt !== 1 || mem_re !== 4'hF) begin fail++; $display("FAIL reset_comb_gnt: got g=%b re=%h want 1 F", i_gnt, mem_re); end
        tick();
        #1;
        vec++; if (i_rvalid !== 0) begin fail++; $display("FAIL reset_no_tag: got %b want 0", i_rvalid); end
        i_req = 0;
        rstn = 0;
        tick();
    endtask

    task automatic test_i_only();
        apply_reset();
        i_req = 1; i_addr = 16'h0040;
        #1;
        vec++; if (i_gnt !== 1 || d_gnt !== 0) begin fail++; $display("FAIL i_only_gnt: got %b%b want 10", i_gnt, d_gnt); end
        vec++; if (mem_a !== 14'h010 || mem_re !== 4'hF || mem_e !== 1 || mem_we !== 0) begin fail++; $display("FAIL i_only_mem: got a=%h re=%h e=%b we=%h want 010 F 1 0", mem_a, mem_re, mem_e, mem_we); end
        push_i();
        tick();
        i_req = 0;
        #1;
        vec++; if (i_rvalid !== 1 || i_rdata !== mem_rd) begin fail++; $display("FAIL i_only_data: got v=%b d=%h want 1 %h", i_rvalid, i_rdata, mem_rd); end
        tick();
    endtask

    task automatic test_d_priority();
        apply_reset();
        i_req = 1; i_addr = 16'h0044; d_req = 1; d_re = 4'hF; d_addr = 16'h0100;
        #1;
        vec++; if (d_gnt !== 1 || i_gnt !== 0) begin fail++; $display("FAIL dpri_gnt: got d=%b i=%b want 1 0", d_gnt, i_gnt); end
        vec++; if (mem_a !== 14'h040 || mem_re !== 4'hF) begin fail++; $display("FAIL dpri_mem: got a=%h re=%h want 040 F", mem_a, mem_re); end
        push_d(4'hF);
        tick();
        d_req = 0;
        #1;
        vec++; if (i_stall_cnt !== 16'd1) begin fail++; $display("FAIL dpri_stall: got %0d want 1", i_stall_cnt); end
        vec++; if (i_gnt !== 1 || mem_a !== 14'h011) begin fail++; $display("FAIL dpri_i_next: got g=%b a=%h want 1 011", i_gnt, mem_a); end
        push_i();
        tick();
        i_req = 0;
        tick();
    endtask

    task automatic test_starve();
        logic ig;
        apply_reset();
        i_req = 1; i_addr = 16'h0080; d_req = 1; d_re = 4'hF; d_addr = 16'h0200;
        for (int c = 1; c <= 10; c++) begin
            #1;
            ig = (c == 5 || c == 10);
            vec++; if (i_gnt !== ig || d_gnt !== !ig) begin fail++; $display("FAIL starve_gnt c%0d: got i=%b d=%b want i=%b d=%b", c, i_gnt, d_gnt, ig, !ig); end
            if (c == 6) begin
                vec++; if (i_stall_cnt !== 16'd4) begin fail++; $display("FAIL starve_istall: got %0d want 4", i_stall_cnt); end
                vec++; if (d_stall_cnt !== 16'd1) begin fail++; $display("FAIL starve_dstall: got %0d want 1", d_stall_cnt); end
            end
            if (ig) push_i(); else push_d(4'hF);
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        apply_reset();
        d_req = 1; d_we = 4'b0101; d_wd = 32'hAABB_CCDD; d_addr = 16'h0008; d_re = 4'hF;
        #1;
        vec++; if (d_gnt !== 1 || mem_we !== 4'b0101 || mem_re !== 4'h0 || mem_e !== 1) begin fail++; $display("FAIL wr_cmd: got g=%b we=%b re=%h e=%b want 1 0101 0 1", d_gnt, mem_we, mem_re, mem_e); end
        vec++; if (mem_a !== 14'h002 || mem_wd !== 32'hAABB_CCDD) begin fail++; $display("FAIL wr_addr: got a=%h wd=%h want 002 aabbccdd", mem_a, mem_wd); end
        tick();
        d_req = 0; d_we = 0; d_wd = 32'h1111_2222; d_addr = 16'h0FF0;
        #1;
        vec++; if (mem_e !== 0 || mem_we !== 0 || mem_re !== 0) begin fail++; $display("FAIL idle_cmd: got e=%b we=%h re=%h want 0 0 0", mem_e, mem_we, mem_re); end
        vec++; if (mem_a !== 14'h002 || mem_wd !== 32'hAABB_CCDD) begin fail++; $display("FAIL idle_hold: got a=%h wd=%h want 002 aabbccdd", mem_a, mem_wd); end
        d_req = 1; d_re = 0; d_addr = 16'h000C;
        #1;
        vec++; if (d_gnt !== 1 || mem_e !== 0) begin fail++; $display("FAIL noop_gnt: got g=%b e=%b want 1 0", d_gnt, mem_e); end
        tick();
        d_req = 0;
        tick();
    endtask

    task automatic test_lane_mask();
        apply_reset();
        d_req = 1; d_re = 4'b0011; d_addr = 16'h0010;
        #1;
        vec++; if (mem_re !== 4'b0011 || mem_a !== 14'h004) begin fail++; $display("FAIL lane_cmd: got re=%b a=%h want 0011 004", mem_re, mem_a); end
        push_d(4'b0011);
        tick();
        d_req = 0;
        mem_rd = 32'h1234_5678;
        #1;
        vec++; if (d_rvalid !== 1 || d_rdata !== 32'h0000_5678) begin fail++; $display("FAIL lane_data: got v=%b d=%h want 1 00005678", d_rvalid, d_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] res [4];
        res = '{4'hF, 4'h1, 4'hC, 4'h6};
        apply_reset();
        d_req = 1;
        for (int k = 0; k < 4; k++) begin
            d_re = res[k]; d_addr = 16'(16'h0400 + 4 * k);
            #1;
            vec++; if (d_gnt !== 1 || mem_re !== res[k] || mem_a !== 14'(14'h100 + k)) begin fail++; $display("FAIL b2b_d k%0d: got g=%b re=%h a=%h want 1 %h %h", k, d_gnt, mem_re, mem_a, res[k], 14'h100 + k); end
            push_d(res[k]);
            tick();
        end
        d_req = 0; i_req = 1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 16'(16'h0800 + 4 * k);
            #1;
            vec++; if (i_gnt !== 1 || mem_a !== 14'(14'h200 + k)) begin fail++; $display("FAIL b2b_i k%0d: got g=%b a=%h want 1 %h", k, i_gnt, mem_a, 14'h200 + k); end
            push_i();
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        i_req = 1; d_req = 1; d_re = 4'hF; d_addr = 16'h0030; i_addr = 16'h0034;
        for (int c = 1; c <= 4; c++) begin
            #1;
            vec++; if (d_gnt !== 1 || i_gnt !== 0) begin fail++; $display("FAIL inflight_gnt c%0d: got d=%b i=%b want 1 0", c, d_gnt, i_gnt); end
            if (c < 4) push_d(4'hF);
            tick();
        end
        // Cycle 4's read is in flight and the FSM has just moved to STARVE.
        rstn = 1;
        #1;
        vec++; if (d_rvalid !== 0 || d_rdata !== 0) begin fail++; $display("FAIL inflight_drop: got v=%b d=%h want 0 0", d_rvalid, d_rdata); end
        vec++; if (i_stall_cnt !== 0 || d_stall_cnt !== 0) begin fail++; $display("FAIL inflight_cnt: got %0d %0d want 0 0", i_stall_cnt, d_stall_cnt); end
        vec++; if (d_gnt !== 1 || i_gnt !== 0) begin fail++; $display("FAIL inflight_norm: got d=%b i=%b want 1 0", d_gnt, i_gnt); end
        tick();
        rstn = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_saturate();
        logic ig;
        apply_reset();
        i_req = 1; d_req = 1; d_re = 4'hF; d_addr = 16'h0060; i_addr = 16'h0064;
        for (int c = 1; c <= 21; c++) begin
            #1;
            ig = (c % 5 == 0);
            vec++; if (i_gnt !== ig) begin fail++; $display("FAIL sat_gnt c%0d: got %b want %b", c, i_gnt, ig); end
            if (c == 18) begin
                vec++; if (s_i_stall_cnt !== 4'hE) begin fail++; $display("FAIL sat_pre: got %h want e", s_i_stall_cnt); end
            end
            if (ig) push_i(); else push_d(4'hF);
            tick();
        end
        #1;
        vec++; if (s_i_stall_cnt !== 4'hF) begin fail++; $display("FAIL sat_hold: got %h want f", s_i_stall_cnt); end
        vec++; if (i_stall_cnt !== 16'd17) begin fail++; $display("FAIL sat_wide: got %0d want 17", i_stall_cnt); end
        clear_inputs();
        tick();
    endtask

    initial begin
        mem_rd = 0;
        test_reset();
        test_i_only();
        test_d_priority();
        test_starve();
        test_write();
        test_lane_mask();
        test_back_to_back();
        test_reset_inflight();
        test_saturate();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
        $finish;
    end

endmodule
